trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap sequencer that drives the machine-mode CSR file rather than serving it.
- Detects ecall / unimp / mret in EX, stalls and flushes the pipeline, and issues ordered CSR writes (mepc, mcause, mstatus) over a valid/ready write port.
- Redirects the PC to the trap vector on trap entry, or to mepc on mret.
- Sits between the EX stage, the CSR unit and the PC/IF logic.

Parameters:
- XLEN, 32, data and PC width.
- CAUSE_ECALL, 11, mcause value written on ecall.
- CAUSE_ILLEGAL, 2, mcause value written on unimp.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_inst  in  32  EX instruction word.
- ex_pc  in  32  EX instruction address.
- mtvec_in  in  32  current mtvec from CSR unit.
- mepc_in  in  32  current mepc from CSR unit.
- mstatus_in  in  32  current mstatus from CSR unit.
- csr_wr_valid  out  1  write request to CSR unit.
- csr_wr_addr  out  12  target CSR address.
- csr_wr_data  out  32  write value.
- csr_wr_ready  in  1  CSR unit accepts the write this cycle.
- stall  out  1  freeze IF/ID/EX.
- flush  out  1  one-cycle kill of IF/ID/EX contents.
- redirect_valid  out  1  one-cycle PC load strobe.
- redirect_pc  out  32  new PC.
- busy  out  1  state != IDLE.

Behaviour:
- Decode, in IDLE with ex_valid=1:
  - ecall = 32'h00000073
  - unimp = 32'hc0001073
  - mret = 32'h30200073
  - Any other word is ignored.
- On a match in cycle T: latch ex_pc, ex_inst, cause, is_mret and mstatus_in; next state is FLUSH.
- States: IDLE, FLUSH, WR_EPC, WR_CAUSE, [WR_TVAL], WR_STATUS, REDIRECT.
- Trap path: FLUSH -> WR_EPC -> WR_CAUSE -> [WR_TVAL] -> WR_STATUS -> REDIRECT -> IDLE.
- mret path: FLUSH -> WR_STATUS -> REDIRECT -> IDLE.
- FLUSH: flush=1 for exactly this cycle.
- stall: 1 in every non-IDLE state.
- Write states:
  - csr_wr_valid=1 with address/data stable until the cycle csr_wr_ready=1, then advance.
  - No timeout.
  - Addr/data remain stable while ready=0.
- Write targets:
  - WR_EPC: addr 12'h341, data = latched pc.
  - WR_CAUSE: addr 12'h342, data = {1'b0, 31-bit cause}.
  - WR_STATUS, trap: addr 12'h300, data = latched mstatus with bit7 (MPIE) <= bit3 (MIE), bit3 <= 0, bits[12:11] <= 2'b11.
  - WR_STATUS, mret: addr 12'h300, data = latched mstatus with bit3 <= bit7, bit7 <= 1, bits[12:11] <= 2'b11.
- REDIRECT: redirect_valid=1 for one cycle.
  - Trap: redirect_pc = {mtvec_in[31:2], 2'b00}.
  - mret: redirect_pc = mepc_in.
  - Both are sampled in this cycle.
- Latency, with ready tied high:
  - Trap: redirect at T+5 (T+6 with MTVAL).
  - mret: redirect at T+3.
  - busy falls the cycle after redirect.
- Matches while busy are ignored; EX is stalled, so the same instruction is not re-detected.
- After REDIRECT the flushed EX shows new contents; detection resumes in IDLE only.
- ex_valid=0 with a matching word: no action.
- Reset at any time, including mid-write: immediate return to IDLE.
  - No completion of the partial sequence.
- Reset values: all outputs 0, busy 0, redirect_pc 0, latches 0.
- csr_wr_addr/csr_wr_data read 0 whenever csr_wr_valid=0.

Optional Feature:
- TRAP_MTVAL_EN defined:
  - Adds state WR_TVAL between WR_CAUSE and WR_STATUS, addr 12'h343.
  - Data = latched inst for unimp, 0 for ecall.
  - Trap latency +1.
- TRAP_MTVAL_EN undefined: state absent, mtval never written.

Test Plan:
- ecall at pc 0x00000100, ex_valid=1, mtvec_in=0x00000801, mstatus_in=0x00000008, ready=1 -> flush at T+1; writes (341,0x100), (342,0x0B), (300,0x00001880); redirect_pc=0x00000800 at T+5.
- unimp at pc 0x00000204 with TRAP_MTVAL_EN -> writes (341,0x204), (342,0x2), (343,0xc0001073), then mstatus; redirect at T+6.
- mret, mepc_in=0x00000104, mstatus_in=0x00001880 -> single write (300,0x00001888); redirect_pc=0x104 at T+3; no 341/342 writes.
- ecall with csr_wr_ready held 0 for 3 cycles in WR_EPC -> valid/addr/data stable for those 3 cycles; stall held; sequence resumes on ready=1.
- rst_n pulled low during WR_CAUSE -> all outputs 0 immediately; after release, no redirect occurs; the next ecall is handled from IDLE normally.
- Second matching inst presented while busy, and an ecall word with ex_valid=0 in IDLE -> neither triggers a new sequence.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer: catches ecall/unimp/mret in EX, stalls and flushes the pipe,
// issues ordered CSR writes and redirects the PC. Define TRAP_MTVAL_EN to add the mtval write.
module trap_ctrl #(
  parameter int XLEN          = 32,
  parameter int CAUSE_ECALL   = 11,
  parameter int CAUSE_ILLEGAL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] mstatus_in,
  output logic            csr_wr_valid,
  output logic [11:0]     csr_wr_addr,
  output logic [XLEN-1:0] csr_wr_data,
  input  logic            csr_wr_ready,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  // state     | meaning
  // IDLE      | watching EX for ecall / unimp / mret
  // FLUSH     | one-cycle kill of IF/ID/EX
  // WR_EPC    | write mepc = trapping pc
  // WR_CAUSE  | write mcause
  // WR_TVAL   | write mtval (TRAP_MTVAL_EN only)
  // WR_STATUS | write updated mstatus (trap entry or mret)
  // REDIRECT  | one-cycle PC load, then back to IDLE
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FLUSH     = 3'd1;
  localparam logic [2:0] WR_EPC    = 3'd2;
  localparam logic [2:0] WR_CAUSE  = 3'd3;
`ifdef TRAP_MTVAL_EN
  localparam logic [2:0] WR_TVAL   = 3'd4;
`endif
  localparam logic [2:0] WR_STATUS = 3'd5;
  localparam logic [2:0] REDIRECT  = 3'd6;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_UNIMP = 32'hc000_1073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef TRAP_MTVAL_EN
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
`endif

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [30:0]     cause_q;
  logic            is_mret_q;
  logic [XLEN-1:0] mstatus_q;
`ifdef TRAP_MTVAL_EN
  logic [31:0]     inst_q;
`endif

  logic            is_ecall, is_unimp, is_mret, trap_hit;
  logic            wr_done;
  logic [XLEN-1:0] status_data;
  logic            unused_tvec_bits;

  // The low mtvec bits select vectored mode, which this core does not use.
  assign unused_tvec_bits = &{1'b0, mtvec_in[1:0]};

  assign is_ecall = (ex_inst == INST_ECALL);
  assign is_unimp = (ex_inst == INST_UNIMP);
  assign is_mret  = (ex_inst == INST_MRET);
  assign trap_hit = ex_valid && (state == IDLE) && (is_ecall || is_unimp || is_mret);
  assign wr_done  = csr_wr_valid && csr_wr_ready;

  always_comb begin
    status_data        = mstatus_q;
    status_data[12:11] = 2'b11;
    if (is_mret_q) begin
      status_data[3] = mstatus_q[7];
      status_data[7] = 1'b1;
    end else begin
      status_data[7] = mstatus_q[3];
      status_data[3] = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (trap_hit) state_nxt = FLUSH;
      FLUSH:     state_nxt = is_mret_q ? WR_STATUS : WR_EPC;
      WR_EPC:    if (wr_done) state_nxt = WR_CAUSE;
`ifdef TRAP_MTVAL_EN
      WR_CAUSE:  if (wr_done) state_nxt = WR_TVAL;
      WR_TVAL:   if (wr_done) state_nxt = WR_STATUS;
`else
      WR_CAUSE:  if (wr_done) state_nxt = WR_STATUS;
`endif
      WR_STATUS: if (wr_done) state_nxt = REDIRECT;
      REDIRECT:  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      is_mret_q <= 1'b0;
      mstatus_q <= '0;
    end else begin
      state <= state_nxt;
      if (trap_hit) begin
        pc_q      <= ex_pc;
        cause_q   <= is_ecall ? 31'(CAUSE_ECALL) : is_unimp ? 31'(CAUSE_ILLEGAL) : 31'd0;
        is_mret_q <= is_mret;
        mstatus_q <= mstatus_in;
      end
    end
  end

`ifdef TRAP_MTVAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q <= '0;
    end else if (trap_hit) begin
      inst_q <= ex_inst;
    end
  end
`endif

  // Outputs decode from state only, so an async reset clears them at once.
  always_comb begin
    csr_wr_valid   = 1'b0;
    csr_wr_addr    = '0;
    csr_wr_data    = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      FLUSH: flush = 1'b1;
      WR_EPC: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = ADDR_MEPC;
        csr_wr_data  = pc_q;
      end
      WR_CAUSE: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = ADDR_MCAUSE;
        csr_wr_data  = XLEN'({1'b0, cause_q});
      end
`ifdef TRAP_MTVAL_EN
      WR_TVAL: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = ADDR_MTVAL;
        csr_wr_data  = (cause_q == 31'(CAUSE_ILLEGAL)) ? XLEN'(inst_q) : '0;
      end
`endif
      WR_STATUS: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = ADDR_MSTATUS;
        csr_wr_data  = status_data;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = is_mret_q ? mepc_in : {mtvec_in[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign stall = (state != IDLE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table, hand-written corner sequences
// and randomized traffic against a cycle-timeline reference model.
module tb_trap_ctrl;

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] UNIMP = 32'hc000_1073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef TRAP_MTVAL_EN
  localparam int MT = 1;
`else
  localparam int MT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_inst = '0, ex_pc = '0, mtvec_in = '0, mepc_in = '0, mstatus_in = '0;
  logic        csr_wr_ready = 1'b0;
  logic        csr_wr_valid, stall, flush, redirect_valid, busy;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data, redirect_pc;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in), .mstatus_in(mstatus_in),
    .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_wr_ready(csr_wr_ready), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rdy_pat [128];

  typedef struct {
    logic        valid;
    logic [31:0] inst, pc, mtvec, mepc, mstatus;
    int          hold;
    logic        exp_trig;
    logic [31:0] exp_status, exp_rpc;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference mstatus updates, written as mask-and-merge arithmetic.
  function automatic logic [31:0] trap_status(input logic [31:0] ms);
    logic [31:0] mie;
    mie = (ms >> 3) & 32'd1;
    return (ms & ~32'h0000_1888) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] ms);
    logic [31:0] mpie;
    mpie = (ms >> 7) & 32'd1;
    return (ms & ~32'h0000_1888) | (mpie << 3) | 32'h0000_1880;
  endfunction

  function automatic logic [31:0] rand_match();
    case ($urandom_range(0, 2))
      0: return ECALL;
      1: return UNIMP;
      default: return MRET;
    endcase
  endfunction

  // Presents one EX instruction and checks every output for each following cycle.
  // rd_off < 0 means the redirect cycle is derived from the ready pattern.
  task automatic run_seq(input logic valid, input logic [31:0] inst, pc, mtvec, mepc, mstatus,
                         input logic trig, input logic [31:0] status, rpc,
                         input int rd_off_in, input string tag);
    wr_t         wq[$];
    logic        ev [128];
    logic [11:0] ea [128];
    logic [31:0] ed [128];
    int          c, last, rd_off;
    logic        exp_busy;
    for (int k = 0; k < 128; k++) begin
      ev[k] = 1'b0; ea[k] = '0; ed[k] = '0;
    end
    rd_off = rd_off_in;
    if (trig) begin
      if (inst == MRET) begin
        wq.push_back('{12'h300, status});
      end else begin
        wq.push_back('{12'h341, pc});
        wq.push_back('{12'h342, (inst == ECALL) ? 32'd11 : 32'd2});
        if (MT == 1) wq.push_back('{12'h343, (inst == UNIMP) ? inst : 32'd0});
        wq.push_back('{12'h300, status});
      end
      c = 2;
      foreach (wq[i]) begin
        while (!rdy_pat[c]) begin
          ev[c] = 1'b1; ea[c] = wq[i].a; ed[c] = wq[i].d; c++;
        end
        ev[c] = 1'b1; ea[c] = wq[i].a; ed[c] = wq[i].d; c++;
      end
      if (rd_off < 0) rd_off = c;
      last = rd_off + 1;
    end else begin
      rd_off = -1;
      last = 3;
    end

    ex_valid = valid; ex_inst = inst; ex_pc = pc;
    mtvec_in = mtvec; mepc_in = mepc; mstatus_in = mstatus;
    csr_wr_ready = rdy_pat[0];
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_busy = trig && (k <= rd_off);
      chk({tag, " flush"},   32'(flush),          32'(trig && k == 1));
      chk({tag, " stall"},   32'(stall),          32'(exp_busy));
      chk({tag, " busy"},    32'(busy),           32'(exp_busy));
      chk({tag, " wvalid"},  32'(csr_wr_valid),   32'(ev[k]));
      chk({tag, " waddr"},   32'(csr_wr_addr),    32'(ea[k]));
      chk({tag, " wdata"},   csr_wr_data,         ed[k]);
      chk({tag, " rvalid"},  32'(redirect_valid), 32'(k == rd_off));
      chk({tag, " rpc"},     redirect_pc,         (k == rd_off) ? rpc : 32'd0);
      csr_wr_ready = rdy_pat[k];
      if (trig && k < rd_off) begin
        ex_inst    = rand_match();
        ex_valid   = 1'b1;
        mstatus_in = $urandom;
      end else if (trig && k == rd_off) begin
        ex_inst = NOP;
      end
    end
    ex_valid = 1'b0;
    ex_inst  = NOP;
  endtask

  task automatic set_ready(input int hold);
    for (int k = 0; k < 128; k++) rdy_pat[k] = 1'b1;
    for (int k = 2; k < 2 + hold; k++) rdy_pat[k] = 1'b0;
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, ECALL, 32'h100, 32'h801,  32'h0,         32'h8,         0, 1'b1, 32'h1880,     32'h800,       5 + MT};
    tbl[1] = '{1'b1, UNIMP, 32'h204, 32'h2000, 32'h0,         32'h0,         0, 1'b1, 32'h1800,     32'h2000,      5 + MT};
    tbl[2] = '{1'b1, MRET,  32'h400, 32'h801,  32'h104,       32'h1880,      0, 1'b1, 32'h1888,     32'h104,       3};
    tbl[3] = '{1'b1, ECALL, 32'h100, 32'h803,  32'h0,         32'h88,        3, 1'b1, 32'h1880,     32'h800,       5 + MT};
    tbl[4] = '{1'b1, MRET,  32'h10,  32'h0,    32'h8000_0000, 32'h0,         0, 1'b1, 32'h1880,     32'h8000_0000, 3};
    tbl[5] = '{1'b0, ECALL, 32'h100, 32'h801,  32'h0,         32'h8,         0, 1'b0, 32'h0,        32'h0,         0};
    tbl[6] = '{1'b1, 32'h0010_0073, 32'h100, 32'h801, 32'h0,  32'h8,         0, 1'b0, 32'h0,        32'h0,         0};
    tbl[7] = '{1'b1, MRET,  32'h20,  32'h0,    32'h44,        32'hFFFF_FF77, 1, 1'b1, 32'hFFFF_FFF7, 32'h44,       3};
    tbl[8] = '{1'b1, UNIMP, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF7, 2, 1'b1, 32'hFFFF_FF77, 32'hFFFF_FFFC, 5 + MT};

    // Reset state
    set_ready(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy",   32'(busy),         32'd0);
    chk("rst wvalid", 32'(csr_wr_valid), 32'd0);
    chk("rst rpc",    redirect_pc,       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle stall", 32'(stall), 32'd0);
    chk("idle waddr", 32'(csr_wr_addr), 32'd0);

    // Vector table
    foreach (tbl[i]) begin
      set_ready(tbl[i].hold);
      run_seq(tbl[i].valid, tbl[i].inst, tbl[i].pc, tbl[i].mtvec, tbl[i].mepc, tbl[i].mstatus,
              tbl[i].exp_trig, tbl[i].exp_status, tbl[i].exp_rpc,
              tbl[i].exp_trig ? tbl[i].exp_lat + tbl[i].hold : -1, $sformatf("vec%0d", i));
    end

    // Reset in the middle of the mcause write
    set_ready(0);
    csr_wr_ready = 1'b1;
    ex_valid = 1'b1; ex_inst = ECALL; ex_pc = 32'h300;
    mtvec_in = 32'h1000; mepc_in = 32'h0; mstatus_in = 32'h8;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    chk("midrst pre addr", 32'(csr_wr_addr), 32'h342);
    rst_n = 1'b0;
    #1;
    chk("midrst wvalid", 32'(csr_wr_valid),   32'd0);
    chk("midrst waddr",  32'(csr_wr_addr),    32'd0);
    chk("midrst wdata",  csr_wr_data,         32'd0);
    chk("midrst stall",  32'(stall),          32'd0);
    chk("midrst busy",   32'(busy),           32'd0);
    chk("midrst rvalid", 32'(redirect_valid), 32'd0);
    ex_valid = 1'b0; ex_inst = NOP;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("postrst quiet", 32'({redirect_valid, busy, csr_wr_valid, flush}), 32'd0);
    end
    run_seq(1'b1, ECALL, 32'h300, 32'h1000, 32'h0, 32'h8, 1'b1, 32'h1880, 32'h1000, 5 + MT, "postrst");

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic        v, trig;
      logic [31:0] inst, pc, tv, ep, ms, st, rp;
      case ($urandom_range(0, 3))
        0: inst = ECALL;
        1: inst = UNIMP;
        2: inst = MRET;
        default: inst = $urandom;
      endcase
      v  = ($urandom_range(0, 4) != 0);
      pc = $urandom; tv = $urandom; ep = $urandom; ms = $urandom;
      trig = v && (inst == ECALL || inst == UNIMP || inst == MRET);
      st = (inst == MRET) ? mret_status(ms) : trap_status(ms);
      rp = (inst == MRET) ? ep : (tv & 32'hFFFF_FFFC);
      for (int k = 0; k < 128; k++) rdy_pat[k] = (k >= 40) || ($urandom_range(0, 2) != 0);
      run_seq(v, inst, pc, tv, ep, ms, trig, st, rp, -1, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
